irq_pulse_gen: RTL and testbench
================================

// Module: irq_pulse_gen
// PURPOSE
//  Interrupt source for RV32core: drives its single-bit `interrupter` input.
//  Merges N_SRC external request lines and one interval timer into prioritised
//  one-cycle interrupt pulses. Holds off between pulses so the core never sees
//  back-to-back traps. Reports the serviced source id and the pending set.
// PARAMETERS
//  N_SRC    4    number of external request lines (1..15)
//  TW       32   timer counter / period width
//  HOLDOFF  16   max cycles in HOLD before a new pulse is allowed (>=1)
//  IDW      4    width of irq_id; must satisfy 2**IDW > N_SRC
// PORTS
//  clk          in   1      system clock; all state on rising edge
//  rst          in   1      asynchronous, active-low reset
//  src_req      in   N_SRC  external requests, level; rising edge = new request
//  src_mask     in   N_SRC  1 = source enabled; masked edges are dropped
//  timer_en     in   1      1 = interval timer runs
//  timer_period in   TW     timer period in cycles; 0 = timer disabled
//  irq_ack      in   1      core trap-entry ack; ends HOLD early (tie 0 if unused)
//  clr_ovf      in   1      clears the sticky overflow flag
//  interrupter  out  1      one-cycle interrupt pulse to the core (registered)
//  irq_id       out  IDW    id of the last pulsed source; timer id = N_SRC
//  pending      out  N_SRC+1  pending bits; bit N_SRC = timer
//  overflow     out  1      sticky: request arrived while its bit was pending
// BEHAVIOUR
//  Reset (rst=0, async): interrupter=0, irq_id=0, pending=0, overflow=0,
//   FSM=IDLE, timer count=0, edge-detect history=0. Takes effect mid-pulse.
//  Edge detect: src_prev <= src_req every cycle; edge[i]=src_req[i]&~src_prev[i].
//   Level held high gives exactly one request.
//  Timer: runs when timer_en=1 and timer_period!=0. cnt counts 0..period-1;
//   at cnt==period-1 it wraps to 0 and sets pending[N_SRC]. Idle timer or
//   period==0 forces cnt=0. A period change applies from the current cnt;
//   if cnt>=new period, cnt wraps to 0 and does not fire.
//  Pending set: edge[i]&src_mask[i], or timer fire. Set on an already pending
//   bit -> overflow<=1 (sticky), pending stays 1. If set and clear hit the same
//   bit in one cycle, the bit stays 1 with no overflow. clr_ovf and a new
//   overflow in one cycle -> overflow=1.
//  Priority: lowest index wins; the timer (index N_SRC) has lowest priority.
//  FSM (state register; interrupter = registered (next==PULSE)):
//   IDLE : |pending -> PULSE. Latch winner into irq_id; clear its pending bit.
//   PULSE: interrupter=1 for exactly this one cycle -> HOLD; hold_cnt=0.
//   HOLD : interrupter=0. ->IDLE when irq_ack=1 or hold_cnt==HOLDOFF-1,
//          else hold_cnt++. irq_ack outside HOLD is ignored.
//  Latency: edge sampled at clock k -> pending at k -> interrupter high in
//   cycle k+1..k+2 (one full clock), if FSM idle.
//  Min spacing between pulses: 2 cycles (ack at first HOLD cycle);
//   max: HOLDOFF+1.
//  irq_id holds its value until the next pulse. Mask changes never clear
//   existing pending bits.
// TESTING
//  1 reset, src_req[0] 0->1 held 10 cycles -> exactly one 1-cycle pulse,
//    irq_id=0, pending=0 after the pulse.
//  2 src_req[2] and src_req[1] rise in one cycle -> pulse id=1; then HOLDOFF=16
//    cycles; then pulse id=2; gap 17 clocks.
//  3 timer_period=5, timer_en=1, no other src -> pulse id=N_SRC every 17 cycles
//    (holdoff-limited); overflow=1 after the second missed fire; clr_ovf -> 0.
//  4 irq_ack asserted in the first HOLD cycle with src3 pending -> next pulse
//    2 cycles after the previous one.
//  5 src_mask[1]=0, edge on src_req[1] -> no pulse; pending[1]=0.
//  6 rst low during PULSE -> interrupter=0 immediately, all outputs at reset.

Source files
------------

// File: rtl/irq_pulse_gen.sv
// irq_pulse_gen
//   Interrupt source for a single-input core. Merges N_SRC external request
//   lines and one interval timer into prioritised one-cycle interrupt pulses,
//   and enforces a hold-off gap between pulses so the core never sees
//   back-to-back traps. Reports the serviced source id and the pending set.
//
// Ports
//   clk          : system clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   src_req      : external request levels; a rising edge is a new request
//   src_mask     : 1 = source enabled; masked edges are dropped
//   timer_en     : 1 = interval timer runs
//   timer_period : timer period in cycles; 0 disables the timer
//   irq_ack      : core trap-entry ack; ends HOLD early
//   clr_ovf      : clears the sticky overflow flag
//   interrupter  : one-cycle registered interrupt pulse
//   irq_id       : id of the last pulsed source (timer id = N_SRC)
//   pending      : pending bits, bit N_SRC is the timer
//   overflow     : sticky, a request hit an already pending bit
module irq_pulse_gen #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned TW      = 32,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned IDW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_req,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             timer_en,
  input  logic [TW-1:0]    timer_period,
  input  logic             irq_ack,
  input  logic             clr_ovf,
  output logic             interrupter,
  output logic [IDW-1:0]   irq_id,
  output logic [N_SRC:0]   pending,
  output logic             overflow
);

  localparam int unsigned HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [TW-1:0]  TONE    = TW'(1);
  localparam logic [HCW-1:0] HONE    = HCW'(1);
  localparam logic [HCW-1:0] HLAST   = HCW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_SRC-1:0] src_prev_q;
  logic [TW-1:0]    tmr_cnt_q, tmr_cnt_d;
  logic             tmr_fire;
  logic [N_SRC:0]   pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [HCW-1:0]   hold_cnt_q;
  logic             irq_q;
  logic [IDW-1:0]   irq_id_q;

  logic [N_SRC-1:0] src_edge;
  logic [N_SRC:0]   set_vec;
  logic [N_SRC:0]   clr_vec;
  logic [N_SRC:0]   win_oh;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic             hold_done;
  logic             take;

  // ---------------------------------------------------------------------------
  // Edge detection: a level held high yields exactly one request.
  // ---------------------------------------------------------------------------
  assign src_edge = src_req & ~src_prev_q;

  // ---------------------------------------------------------------------------
  // Interval timer. A period shrunk below the current count wraps to 0
  // without firing.
  // ---------------------------------------------------------------------------
  always_comb begin
    tmr_cnt_d = '0;
    tmr_fire  = 1'b0;
    if (timer_en && (timer_period != '0)) begin
      if (tmr_cnt_q == (timer_period - TONE)) begin
        tmr_fire = 1'b1;
      end else if (tmr_cnt_q < timer_period) begin
        tmr_cnt_d = tmr_cnt_q + TONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select: lowest index wins, timer (index N_SRC) is last.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_oh    = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i <= N_SRC; i++) begin
      if (pending_q[i] && !win_found) begin
        win_found = 1'b1;
        win_oh[i] = 1'b1;
        win_id    = IDW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse launch decision. Leaving HOLD with work pending launches the next
  // pulse directly instead of passing through IDLE; this is what makes the
  // pulse spacing 2 cycles minimum and HOLDOFF+1 cycles maximum.
  // ---------------------------------------------------------------------------
  assign hold_done = irq_ack || (hold_cnt_q == HLAST);
  assign take      = win_found &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && hold_done));

  // ---------------------------------------------------------------------------
  // Pending set/clear and sticky overflow. A set landing on the bit being
  // cleared this cycle re-arms it without counting as overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    set_vec    = {tmr_fire, src_edge & src_mask};
    clr_vec    = take ? win_oh : '0;
    pending_d  = (pending_q & ~clr_vec) | set_vec;
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (|(set_vec & pending_q & ~clr_vec)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_prev_q <= '0;
      tmr_cnt_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      src_prev_q <= src_req;
      tmr_cnt_q  <= tmr_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse FSM; interrupter is registered as (next state == PULSE).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_q  <= ST_PULSE;
            irq_q    <= 1'b1;
            irq_id_q <= win_id;
          end
        end
        ST_PULSE: begin
          state_q    <= ST_HOLD;
          hold_cnt_q <= '0;
        end
        ST_HOLD: begin
          if (hold_done) begin
            if (take) begin
              state_q  <= ST_PULSE;
              irq_q    <= 1'b1;
              irq_id_q <= win_id;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupter = irq_q;
  assign irq_id      = irq_id_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_pulse_gen.sv
module tb_irq_pulse_gen;

  localparam int N_SRC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] src_req;
  logic [N_SRC-1:0] src_mask;
  logic             timer_en;
  logic [31:0]      timer_period;
  logic             irq_ack;
  logic             clr_ovf;
  logic             interrupter;
  logic [3:0]       irq_id;
  logic [N_SRC:0]   pending;
  logic             overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;
  int pq[$];
  int idq[$];

  irq_pulse_gen #(
    .N_SRC  (4),
    .TW     (32),
    .HOLDOFF(16),
    .IDW    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_req     (src_req),
    .src_mask    (src_mask),
    .timer_en    (timer_en),
    .timer_period(timer_period),
    .irq_ack     (irq_ack),
    .clr_ovf     (clr_ovf),
    .interrupter (interrupter),
    .irq_id      (irq_id),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: cycle index and id of every interrupter-high cycle.
  always @(negedge clk) begin
    if (interrupter === 1'b1) begin
      pq.push_back(cyc);
      idq.push_back(int'(irq_id));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; src_req = '0; src_mask = '1; timer_en = 1'b0;
    timer_period = '0; irq_ack = 1'b0; clr_ovf = 1'b0;
    tick(3);
    check("rst_irq", 32'(interrupter), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick(2);

    // Held level gives exactly one pulse, one clock wide.
    pq.delete(); idq.delete();
    src_req[0] = 1'b1;
    tick(1);
    check("t1_pend", 32'(pending), 32'h01);
    check("t1_irq_early", 32'(interrupter), 32'd0);
    tick(1);
    check("t1_irq", 32'(interrupter), 32'd1);
    check("t1_id", 32'(irq_id), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'd0);
    tick(1);
    check("t1_width", 32'(interrupter), 32'd0);
    tick(8);
    src_req = '0;
    tick(20);
    check("t1_npulse", 32'(pq.size()), 32'd1);

    // Simultaneous requests: priority order and holdoff-limited gap.
    pq.delete(); idq.delete();
    src_req = 4'b0110;
    tick(30);
    check("t2_npulse", 32'(pq.size()), 32'd2);
    check("t2_id0", 32'(idq[0]), 32'd1);
    check("t2_id1", 32'(idq[1]), 32'd2);
    check("t2_gap", 32'(pq[1] - pq[0]), 32'd17);
    check("t2_pend", 32'(pending), 32'd0);
    src_req = '0;
    tick(20);

    // Ack in the first HOLD cycle: next pulse two cycles later.
    src_req = 4'b1001;
    tick(2);
    check("t4_irq0", 32'(interrupter), 32'd1);
    check("t4_id0", 32'(irq_id), 32'd0);
    tick(1);
    check("t4_hold", 32'(interrupter), 32'd0);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t4_irq1", 32'(interrupter), 32'd1);
    check("t4_id1", 32'(irq_id), 32'd3);
    src_req = '0;
    tick(20);

    // Masked edge is dropped.
    pq.delete(); idq.delete();
    src_mask = 4'b1101;
    src_req[1] = 1'b1;
    tick(1);
    check("t5_pend", 32'(pending), 32'd0);
    tick(10);
    check("t5_npulse", 32'(pq.size()), 32'd0);
    src_req = '0;
    src_mask = '1;
    tick(2);

    // Enabled timer with period 0 never fires.
    pq.delete(); idq.delete();
    timer_en = 1'b1;
    timer_period = 32'd0;
    tick(20);
    check("tp0_npulse", 32'(pq.size()), 32'd0);
    check("tp0_pend", 32'(pending), 32'd0);

    // Timer period 5: fires at +5,+10,+15,...; pulses at +6,+23,+40.
    pq.delete(); idq.delete();
    timer_period = 32'd5;
    c0 = cyc;
    tick(14);
    check("t3_ovf_pre", 32'(overflow), 32'd0);
    tick(1);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    tick(30);
    check("t3_npulse", 32'(pq.size()), 32'd3);
    check("t3_first", 32'(pq[0] - c0), 32'd6);
    check("t3_gap1", 32'(pq[1] - pq[0]), 32'd17);
    check("t3_gap2", 32'(pq[2] - pq[1]), 32'd17);
    check("t3_id", 32'(idq[0]), 32'd4);
    timer_en = 1'b0;
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    tick(40);

    // Asynchronous reset in the middle of a pulse.
    src_req = 4'b1100;
    tick(2);
    check("t6_irq", 32'(interrupter), 32'd1);
    check("t6_id", 32'(irq_id), 32'd2);
    check("t6_pend", 32'(pending), 32'h08);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_irq", 32'(interrupter), 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    src_req = '0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
